// File: rtl/vga_update_scheduler_if.sv
// rtl/vga_update_scheduler_if.sv - game/cpu/display-bus signal bundle for the update scheduler
interface vga_update_scheduler_if #(
    parameter int DW = 10
);
    logic [3:0]      upd_valid;
    logic [4*DW-1:0] upd_data;
    logic            cpu_valid;
    logic [1:0]      cpu_addr;
    logic [DW-1:0]   cpu_data;
    logic            cpu_ready;
    logic            frame_tick;
    logic            sel;
    logic [1:0]      addr;
    logic [DW-1:0]   data_out;
    logic            busy;
    logic            frame_done;
    logic            overrun;

    modport master (
        output upd_valid, upd_data, cpu_valid, cpu_addr, cpu_data, frame_tick,
        input  cpu_ready, sel, addr, data_out, busy, frame_done, overrun
    );

    modport slave (
        input  upd_valid, upd_data, cpu_valid, cpu_addr, cpu_data, frame_tick,
        output cpu_ready, sel, addr, data_out, busy, frame_done, overrun
    );
endinterface

// File: rtl/vga_update_scheduler.sv
// rtl/vga_update_scheduler.sv - coalesces position updates and flushes dirty entries once per frame
module vga_update_scheduler #(
    parameter int DW  = 10,
    parameter int GAP = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    vga_update_scheduler_if.slave   bus
);
    localparam int GW = (GAP < 1) ? 1 : $clog2(GAP + 1);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t        state, state_nx;
    logic [DW-1:0] shadow [4];
    logic [3:0]    dirty, fm;
    logic [GW-1:0] gap_cnt;

    logic [3:0]    cpu_mask, pick_oh, fm_nx, dirty_nx;
    logic [1:0]    pick;
    logic          issue, fm_empty, merge_nonzero;

    logic          sel_d, frame_done_d, overrun_d;
    logic [1:0]    addr_d;
    logic [DW-1:0] data_d;

    assign bus.cpu_ready = bus.cpu_valid & ~rst;
    assign bus.busy      = (state == FLUSH);

    assign cpu_mask = bus.cpu_valid ? (4'b0001 << bus.cpu_addr) : 4'b0000;
    assign fm_empty = (fm == 4'b0000);
    assign issue    = (state == FLUSH) && !fm_empty && (gap_cnt == '0) && !bus.cpu_valid;

    // Descending scan so the lowest set bit of fm wins.
    always_comb begin
        pick = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (fm[i]) pick = 2'(i);
        end
        pick_oh = issue ? (4'b0001 << pick) : 4'b0000;
    end

    always_comb begin
        fm_nx    = fm & ~(pick_oh | cpu_mask);
        dirty_nx = dirty & ~cpu_mask;
        if (bus.frame_tick) begin
            fm_nx    = fm_nx | dirty_nx;
            dirty_nx = 4'b0000;
        end
        dirty_nx      = dirty_nx | bus.upd_valid;
        merge_nonzero = bus.frame_tick && ((dirty & ~cpu_mask) != 4'b0000);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; a tick landing on the final cycle with new work keeps the window open.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.frame_tick) state_nx = FLUSH;
            FLUSH:   if (fm_empty && !merge_nonzero) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic: values the bus registers take at the next edge.
    always_comb begin
        sel_d        = bus.cpu_valid | issue;
        addr_d       = bus.cpu_valid ? bus.cpu_addr : pick;
        data_d       = bus.cpu_valid ? bus.cpu_data : shadow[pick];
        frame_done_d = (state == FLUSH) && (state_nx == IDLE);
        overrun_d    = (state == FLUSH) && bus.frame_tick;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.sel        <= 1'b0;
            bus.addr       <= 2'd0;
            bus.data_out   <= '0;
            bus.frame_done <= 1'b0;
            bus.overrun    <= 1'b0;
            dirty          <= 4'b0000;
            fm             <= 4'b0000;
            gap_cnt        <= '0;
            for (int i = 0; i < 4; i++) shadow[i] <= '0;
        end else begin
            bus.sel        <= sel_d;
            bus.addr       <= addr_d;
            bus.data_out   <= data_d;
            bus.frame_done <= frame_done_d;
            bus.overrun    <= overrun_d;
            dirty          <= dirty_nx;
            fm             <= fm_nx;
            if (issue)
                gap_cnt <= GW'(GAP);
            else if (gap_cnt != '0)
                gap_cnt <= gap_cnt - 1'b1;
            // Game value is written after the CPU value so it wins on a same-cycle collision.
            for (int i = 0; i < 4; i++) begin
                if (cpu_mask[i])      shadow[i] <= bus.cpu_data;
                if (bus.upd_valid[i]) shadow[i] <= bus.upd_data[i*DW +: DW];
            end
        end
    end
endmodule
